// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the next-PC sequencer and the core (PC register,
// hazard unit, branch/jump resolution). The sequencer sits on the slave modport.
interface pc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pcOut;
  logic             i_stall;
  logic             i_br_taken;
  logic [31:0]      i_br_target;
  logic             i_jr;
  logic [31:0]      i_jr_target;
  logic             i_jump;
  logic [31:0]      i_jump_target;
  logic [31:0]      pcIn;
  logic             o_flush;
  logic [CNT_W-1:0] o_redirect_cnt;
  logic             o_misalign;

  modport master (
    output pcOut, i_stall, i_br_taken, i_br_target, i_jr, i_jr_target,
           i_jump, i_jump_target,
    input  pcIn, o_flush, o_redirect_cnt, o_misalign
  );

  modport slave (
    input  pcOut, i_stall, i_br_taken, i_br_target, i_jr, i_jr_target,
           i_jump, i_jump_target,
    output pcIn, o_flush, o_redirect_cnt, o_misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC source for fetch: sequential, stall hold, and prioritised redirects,
// with one pending-redirect slot while stalled. PC_MISALIGN_TRAP_EN adds the trap.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int          CNT_W        = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             new_vld;
  logic [31:0]      new_tgt;
  logic [31:0]      cand;
  logic             apply;
  logic [31:0]      app_tgt;
  logic [31:0]      pc_seq;

  // Branch resolves later in the pipe than jr/j, so it wins.
  always_comb begin
    new_vld = bus.i_br_taken | bus.i_jr | bus.i_jump;
    new_tgt = bus.i_jump_target;
    if (bus.i_jr)       new_tgt = bus.i_jr_target;
    if (bus.i_br_taken) new_tgt = bus.i_br_target;
  end

  // A fresh redirect always replaces whatever is pending.
  assign cand  = new_vld ? new_tgt : pend_q;
  assign apply = i_rst_n && !bus.i_stall &&
                 ((state_q == ST_RUN && new_vld) || state_q == ST_HELD);
  assign pc_seq = bus.pcOut + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
  logic app_mis;
  logic mis_q, mis_d;

  assign app_mis = apply && (cand[1:0] != 2'b00);
  assign app_tgt = app_mis ? TRAP_VECTOR : cand;
  assign mis_d   = app_mis;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end

  assign bus.o_misalign = mis_q;
`else
  logic unused_trap;

  assign app_tgt        = {cand[31:2], 2'b00};
  assign unused_trap    = ^{TRAP_VECTOR, cand[1:0]};
  assign bus.o_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_BOOT;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (new_vld && bus.i_stall) begin
          state_d = ST_HELD;
          pend_d  = new_tgt;
        end
      end
      ST_HELD: begin
        if (new_vld)      pend_d  = new_tgt;
        if (!bus.i_stall) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (apply && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Reset overrides state so the vector is driven during reset itself.
  always_comb begin
    bus.pcIn    = pc_seq;
    bus.o_flush = 1'b0;
    if (!i_rst_n || state_q == ST_BOOT) begin
      bus.pcIn = RESET_VECTOR;
    end else if (apply) begin
      bus.pcIn    = app_tgt;
      bus.o_flush = 1'b1;
    end else if (bus.i_stall) begin
      bus.pcIn = bus.pcOut;
    end
  end

  assign bus.o_redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plan steps then random traffic, against a pending-slot reference model;
// a second instance with a 2-bit counter covers saturation.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  pc_sequencer_if #(.CNT_W(16)) bus ();
  pc_sequencer_if #(.CNT_W(2))  bus2 ();

  // programCounter stand-in
  logic [31:0] pc_q;
  always @(posedge i_clk) pc_q <= bus.pcIn;
  assign bus.pcOut          = pc_q;
  assign bus2.pcOut         = pc_q;
  assign bus2.i_stall       = bus.i_stall;
  assign bus2.i_br_taken    = bus.i_br_taken;
  assign bus2.i_br_target   = bus.i_br_target;
  assign bus2.i_jr          = bus.i_jr;
  assign bus2.i_jr_target   = bus.i_jr_target;
  assign bus2.i_jump        = bus.i_jump;
  assign bus2.i_jump_target = bus.i_jump_target;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave));
  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus2.slave));

  int checks = 0;
  int fails  = 0;

  // reference model: booting flag, one pending slot, counters, pc register
  bit          m_boot, m_pv, m_mis;
  logic [31:0] m_pt, m_pc;
  int          m_cnt, m_cnt2;
  logic [31:0] e_pc, e_nt;
  bit          e_fl, e_apply, e_cap, e_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] land(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return (t % 4 != 0) ? TV : t;
`else
    return t - (t % 4);
`endif
  endfunction

  task automatic drv(input bit r, input bit s, input bit b, input logic [31:0] bt,
                     input bit jr, input logic [31:0] jrt, input bit j, input logic [31:0] jt);
    i_rst_n           = r;
    bus.i_stall       = s;
    bus.i_br_taken    = b;
    bus.i_br_target   = bt;
    bus.i_jr          = jr;
    bus.i_jr_target   = jrt;
    bus.i_jump        = j;
    bus.i_jump_target = jt;
  endtask

  task automatic idle(input bit s);
    drv(1'b1, s, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cyc_chk();
    bit          nv;
    logic [31:0] cand;
    @(negedge i_clk);
    nv   = bus.i_br_taken || bus.i_jr || bus.i_jump;
    e_nt = bus.i_br_taken ? bus.i_br_target :
           bus.i_jr       ? bus.i_jr_target : bus.i_jump_target;
    cand = nv ? e_nt : m_pt;
    e_apply = 1'b0;
    e_fl    = 1'b0;
    e_mis   = 1'b0;
    e_cap   = i_rst_n && !m_boot && nv && bus.i_stall;
    if (!i_rst_n || m_boot) e_pc = RV;
    else if ((nv || m_pv) && !bus.i_stall) begin
      e_apply = 1'b1;
      e_fl    = 1'b1;
      e_pc    = land(cand);
`ifdef PC_MISALIGN_TRAP_EN
      e_mis   = (cand % 4 != 0);
`endif
    end else e_pc = bus.i_stall ? m_pc : m_pc + 32'd4;
    chk("pcIn",     bus.pcIn, e_pc);
    chk("flush",    32'(bus.o_flush), 32'(e_fl));
    chk("cnt",      32'(bus.o_redirect_cnt), 32'(m_cnt));
    chk("cnt_sat",  32'(bus2.o_redirect_cnt), 32'(m_cnt2));
    chk("misalign", 32'(bus.o_misalign), 32'(m_mis));
    chk("pcOut",    bus.pcOut, m_pc);
  endtask

  task automatic cyc_adv();
    @(posedge i_clk);
    if (!i_rst_n) begin
      m_boot = 1'b1; m_pv = 1'b0; m_pt = 32'h0;
      m_cnt = 0; m_cnt2 = 0; m_mis = 1'b0;
    end else begin
      m_boot = 1'b0;
      m_mis  = e_apply && e_mis;
      if (e_apply) begin
        m_pv = 1'b0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3)    m_cnt2++;
      end else if (e_cap) begin
        m_pv = 1'b1;
        m_pt = e_nt;
      end
    end
    m_pc = e_pc;
    #1;
  endtask

  task automatic cyc();
    cyc_chk();
    cyc_adv();
  endtask

  function automatic logic [31:0] rtgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
    return t;
  endfunction

  initial begin
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    m_boot = 1'b1; m_pv = 1'b0; m_mis = 1'b0; m_pt = 32'h0;
    m_cnt = 0; m_cnt2 = 0; m_pc = RV;
    @(posedge i_clk);
    #1;

    // reset held three cycles, then release
    cyc(); cyc();
    idle(1'b0);
    cyc_chk(); chk("rst_release_pcIn", bus.pcIn, RV); chk("rst_release_flush", 32'(bus.o_flush), 32'h0);
    cyc_adv();
    cyc_chk(); chk("rst_pcOut0", bus.pcOut, RV); cyc_adv();
    cyc_chk(); chk("rst_pcOut4", bus.pcOut, RV + 32'd4); cyc_adv();
    cyc_chk(); chk("rst_pcOut8", bus.pcOut, RV + 32'd8); chk("rst_cnt", 32'(bus.o_redirect_cnt), 32'h0);
    cyc_adv();

    // priority
    drv(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
    cyc_chk(); chk("prio_pcIn", bus.pcIn, 32'h100); chk("prio_flush", 32'(bus.o_flush), 32'h1);
    cyc_adv();
    idle(1'b0);
    cyc_chk(); chk("prio_cnt", 32'(bus.o_redirect_cnt), 32'h1); cyc_adv();

    // stalled redirect, three stall cycles
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h400);
    cyc_chk(); chk("stall_hold", bus.pcIn, m_pc); chk("stall_flush", 32'(bus.o_flush), 32'h0); cyc_adv();
    idle(1'b1);
    cyc(); cyc_chk(); chk("stall_flush3", 32'(bus.o_flush), 32'h0); cyc_adv();
    idle(1'b0);
    cyc_chk(); chk("stall_apply_pc", bus.pcIn, 32'h400); chk("stall_apply_flush", 32'(bus.o_flush), 32'h1);
    cyc_adv();

    // overwrite while held
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h400);
    cyc();
    drv(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    idle(1'b0);
    cyc_chk(); chk("ovw_pc", bus.pcIn, 32'h500); cyc_adv();
    cyc_chk(); chk("ovw_cnt", 32'(bus.o_redirect_cnt), 32'h3); chk("ovw_pcOut", bus.pcOut, 32'h500); cyc_adv();

    // wrap of +4
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    cyc();
    idle(1'b0);
    cyc_chk(); chk("wrap_pcIn", bus.pcIn, 32'h0); cyc_adv();

    // misaligned target (fifth redirect, also saturates the 2-bit counter)
    drv(1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    cyc_chk(); chk("mis_pcIn", bus.pcIn, TV); cyc_adv();
    idle(1'b0);
    cyc_chk(); chk("mis_pulse", 32'(bus.o_misalign), 32'h1); cyc_adv();
`else
    cyc_chk(); chk("mis_pcIn", bus.pcIn, 32'h100); cyc_adv();
    idle(1'b0);
    cyc_chk(); chk("mis_tied0", 32'(bus.o_misalign), 32'h0); cyc_adv();
`endif
    cyc_chk(); chk("mis_clear", 32'(bus.o_misalign), 32'h0);
    chk("sat_cnt", 32'(bus2.o_redirect_cnt), 32'h3); chk("cnt5", 32'(bus.o_redirect_cnt), 32'h5);
    cyc_adv();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drv($urandom_range(0, 99) > 2, $urandom_range(0, 1) == 1,
          $urandom_range(0, 6) == 0, rtgt(),
          $urandom_range(0, 6) == 0, rtgt(),
          $urandom_range(0, 6) == 0, rtgt());
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
